// File: rtl/neurona_scheduler.sv
// ---------------------------------------------------------------------------
// neurona_scheduler
//
// Time-multiplexed controller for the 7x7 binary-image neuron layer. One
// shared accumulator walks through N_NEURONS neurons in turn. For each neuron
// it reads N_PIXELS signed weights from a synchronous ROM and adds the weights
// whose pixel is set. It then keeps the neuron with the highest score. A tie
// keeps the lower index.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        classification request, sampled only while idle
//   pixels       binary image, bit i = pixel i, captured when start is accepted
//   weight_addr  ROM address = neuron*N_PIXELS + pixel index (registered)
//   weight_rd_en ROM read enable (registered)
//   weight_data  signed ROM data, valid one cycle after its address
//   busy         high from the cycle after acceptance through the done cycle
//   done         one-cycle pulse; class_out/score_out are valid with it
//   class_out    index of the winning neuron, held between done pulses
//   score_out    score of the winning neuron, held between done pulses
//   state_dbg    current FSM state (0 idle, 1 run, 2 drain, 3 cmp, 4 done)
//
// Handshake: start is a level sampled on each rising edge while idle. The
// first edge that sees start=1 accepts the request. While busy, start is
// ignored and is not queued. The ROM has no back-pressure. The address issued
// in cycle t is answered on weight_data in cycle t+1.
// ---------------------------------------------------------------------------
module neurona_scheduler #(
    parameter int N_PIXELS   = 49,
    parameter int N_NEURONS  = 10,
    parameter int W_WIDTH    = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int ADDR_WIDTH = 9,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [N_PIXELS-1:0]   pixels,
    output logic [ADDR_WIDTH-1:0] weight_addr,
    output logic                  weight_rd_en,
    input  logic [W_WIDTH-1:0]    weight_data,
    output logic                  busy,
    output logic                  done,
    output logic [IDX_WIDTH-1:0]  class_out,
    output logic [ACC_WIDTH-1:0]  score_out,
    output logic [2:0]            state_dbg
);

    localparam int CNT_W = $clog2(N_PIXELS + 1);
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_CMP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [N_PIXELS-1:0]          pix_r;
    logic [CNT_W-1:0]             idx;
    logic [IDX_WIDTH-1:0]         neuron;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  best_score;
    logic [IDX_WIDTH-1:0]         best_idx;

    logic [CNT_W-1:0]             term_k;
    logic signed [ACC_WIDTH-1:0]  term;
    logic                         last_pixel;
    logic                         last_neuron;
    logic signed [ACC_WIDTH-1:0]  best_score_nxt;
    logic [IDX_WIDTH-1:0]         best_idx_nxt;

    logic [ADDR_WIDTH-1:0]        addr_nxt;
    logic                         rd_en_nxt;
    logic                         busy_nxt;
    logic                         done_nxt;
    logic [IDX_WIDTH-1:0]         class_nxt;
    logic [ACC_WIDTH-1:0]         score_nxt;

    assign last_pixel  = (idx == CNT_W'(N_PIXELS - 1));
    assign last_neuron = (neuron == IDX_WIDTH'(N_NEURONS - 1));
    assign state_dbg   = state;

    // The data on weight_data belongs to the address issued in the previous
    // cycle. So the pixel that gates the term is always idx-1.
    always_comb begin
        term_k = idx - CNT_W'(1);
        term   = '0;
        if (pix_r[term_k]) begin
            term = {{(ACC_WIDTH-W_WIDTH){weight_data[W_WIDTH-1]}}, weight_data};
        end
    end

    // Strict greater-than, so on a tie the earlier (lower) neuron stays best.
    always_comb begin
        best_score_nxt = best_score;
        best_idx_nxt   = best_idx;
        if (state == S_CMP && acc > best_score) begin
            best_score_nxt = acc;
            best_idx_nxt   = neuron;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last_pixel) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_CMP;
            S_CMP:   state_nxt = last_neuron ? S_DONE : S_RUN;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: output logic ----------------
    // These are the values the output registers take on the coming edge. So
    // every output is a flop and is valid in the first cycle of its state.
    always_comb begin
        addr_nxt  = weight_addr;
        rd_en_nxt = (state_nxt == S_RUN);
        busy_nxt  = (state_nxt != S_IDLE);
        done_nxt  = (state_nxt == S_DONE);
        class_nxt = class_out;
        score_nxt = score_out;
        case (state)
            S_IDLE: begin
                if (start) addr_nxt = '0;
            end
            S_RUN: begin
                if (state_nxt == S_RUN) addr_nxt = weight_addr + ADDR_WIDTH'(1);
            end
            S_CMP: begin
                // The neuron bases are contiguous, so the next neuron's first
                // address is the last address issued plus one.
                if (state_nxt == S_RUN) begin
                    addr_nxt = weight_addr + ADDR_WIDTH'(1);
                end else begin
                    class_nxt = best_idx_nxt;
                    score_nxt = best_score_nxt;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            weight_addr  <= '0;
            weight_rd_en <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            class_out    <= '0;
            score_out    <= '0;
        end else begin
            weight_addr  <= addr_nxt;
            weight_rd_en <= rd_en_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            class_out    <= class_nxt;
            score_out    <= score_nxt;
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_r      <= '0;
            idx        <= '0;
            neuron     <= '0;
            acc        <= '0;
            best_score <= '0;
            best_idx   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pix_r      <= pixels;
                        idx        <= '0;
                        neuron     <= '0;
                        acc        <= '0;
                        best_score <= ACC_MIN;
                        best_idx   <= '0;
                    end
                end
                S_RUN: begin
                    idx <= idx + CNT_W'(1);
                    if (idx != '0) acc <= acc + term;
                end
                S_DRAIN: begin
                    acc <= acc + term;
                end
                S_CMP: begin
                    best_score <= best_score_nxt;
                    best_idx   <= best_idx_nxt;
                    acc        <= '0;
                    idx        <= '0;
                    if (!last_neuron) neuron <= neuron + IDX_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/neurona_scheduler.md
# neurona_scheduler

Time-multiplexed controller for the 7×7 binary-image neuron layer. It latches a 49-pixel binary image on `start` and reads signed 8-bit weights from a synchronous weight ROM, one per cycle. It accumulates one neuron at a time through a single shared accumulator, then selects the highest-scoring neuron (argmax). It sits between the image capture logic and the classification output, replacing N_NEURONS parallel 49-input neurons with one sequenced datapath.

## Interface
Parameters:
- `N_PIXELS`, 49, pixels per image, one weight per pixel per neuron
- `N_NEURONS`, 10, number of output neurons (classes)
- `W_WIDTH`, 8, signed weight width
- `ACC_WIDTH`, 16, signed accumulator and score width
- `ADDR_WIDTH`, 9, weight ROM address width; must satisfy 2^ADDR_WIDTH ≥ N_PIXELS·N_NEURONS
- `IDX_WIDTH`, 4, class index width; must satisfy 2^IDX_WIDTH ≥ N_NEURONS

Ports:
- `clk`  in  1  clock; all state updates on its rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request a classification; sampled only in IDLE
- `pixels`  in  N_PIXELS  binary image; bit i is pixel_i; sampled on the accepting edge
- `weight_addr`  out  ADDR_WIDTH  ROM address = neuron·N_PIXELS + pixel index
- `weight_rd_en`  out  1  ROM read enable
- `weight_data`  in  W_WIDTH  signed ROM data; valid one cycle after the address
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle
- `done`  out  1  one-cycle pulse when `class_out` and `score_out` update
- `class_out`  out  IDX_WIDTH  index of the winning neuron
- `score_out`  out  ACC_WIDTH  accumulated sum of the winning neuron

## Operation
- States: IDLE, RUN, DRAIN, CMP, DONE.
- IDLE:
  - `start`=1 captures `pixels` into `pix_r`.
  - Clears `neuron`=0, `idx`=0, `acc`=0, `best_score`=most-negative value, `best_idx`=0.
  - Moves to RUN.
- RUN:
  - Drives `weight_addr`=neuron·N_PIXELS+idx and `weight_rd_en`=1.
  - If idx>0, adds the term for pixel idx−1.
  - idx increments each cycle. At idx=N_PIXELS−1 the next state is DRAIN.
- DRAIN:
  - Adds the term for the last pixel.
  - `weight_rd_en`=0.
- Term rule: term = `pix_r[k]` ? sign-extend(`weight_data`) to ACC_WIDTH : 0.
- Width rule: |sum| ≤ 49·128 = 6272, so no overflow at ACC_WIDTH=16. No saturation logic.
- CMP:
  - If `acc` > `best_score` (signed, strict), sets `best_score`=`acc` and `best_idx`=`neuron`. Ties keep the lower index.
  - Clears `acc` and `idx`.
  - If neuron=N_NEURONS−1, goes to DONE. Otherwise increments neuron and goes to RUN.
- DONE:
  - `class_out`←`best_idx`, `score_out`←`best_score`, `done`=1.
  - Returns to IDLE.
- `start` outside IDLE is ignored, with no queuing.
- Changing `pixels` after acceptance has no effect.
- Reset (async, any state):
  - State=IDLE.
  - All internal registers cleared.
  - `weight_addr`=0, `weight_rd_en`=0, `busy`=0, `done`=0, `class_out`=0, `score_out`=0.
  - No `done` is produced for an aborted run.

## Timing
- Edge E0: IDLE samples `start`=1.
- Neuron n occupies 51 cycles:
  - 49 RUN cycles
  - 1 DRAIN cycle
  - 1 CMP cycle
- Total: N_NEURONS·51 = 510 cycles after E0, then 1 DONE cycle.
- `done`=1 during cycle 511 after E0. `busy` falls with it.
- A new `start` can be accepted in the first cycle after DONE, giving a 512-cycle back-to-back period.
- ROM contract: `weight_data` in cycle t+1 corresponds to `weight_addr` in cycle t. The ROM sees exactly 49 consecutive addresses per neuron, ascending.
- `class_out` and `score_out` hold their values between `done` pulses.
- All outputs are registered.

## Test plan
- Neuron 0 weights = {-1,-2,-3,-2,0,1,0,0,0,2,0,1,1,4,0,0,3,-1,1,0,1,1,1,2,3,6,1,0,-2,-2,1,2,-1,-1,-2,-2,-4,-4,1,0,-1,-2,-1,0,2,2,2,1,-1}; all other weights 0; all pixels 1.
  - Required: `done` at cycle 511, `class_out`=0, `score_out`=7.
  - Required: the ROM address sequence runs 0..489, in 49-address bursts separated by 2 idle cycles.
- Neuron 7 weights all +1, others all 0, all pixels 1 → `class_out`=7, `score_out`=49.
- All pixels 0, random weights → all sums 0 → `class_out`=0 (tie rule), `score_out`=0.
- All weights −128, all pixels 1 → `score_out`=−6272 (0xE780), `class_out`=0.
- Neurons 3 and 5 both score 20, all others lower → `class_out`=3.
- Reset and start handling:
  - `start` re-asserted at cycle 100 is ignored; `done` still arrives exactly at cycle 511.
  - `reset_n` pulsed low at cycle 200 → all outputs 0 immediately, no `done`.
  - The next `start` completes normally 511 cycles later.
